// File: rtl/ctu_clsp_dram_ckseq_pkg.sv
// Shared definitions for the DRAM-domain reset / cken sequencer.
// Holds the 3-bit sequencer state encoding, the per-channel cken index
// constants and a small helper that turns a channel index into a one-hot mask.
package ctu_clsp_dram_ckseq_pkg;

    // Number of cken channels driven by the sequencer.
    localparam int NUM_CH = 6;

    // Width of the channel index register (covers 0..NUM_CH-1).
    localparam int IDX_W = 3;

    // Channel index constants, in cken_mask / cken_dg bit order.
    localparam logic [IDX_W-1:0] CH_DRAM02 = 3'd0;
    localparam logic [IDX_W-1:0] CH_DRAM13 = 3'd1;
    localparam logic [IDX_W-1:0] CH_DDR0   = 3'd2;
    localparam logic [IDX_W-1:0] CH_DDR1   = 3'd3;
    localparam logic [IDX_W-1:0] CH_DDR2   = 3'd4;
    localparam logic [IDX_W-1:0] CH_DDR3   = 3'd5;

    // Ramp-up walks CH_FIRST..CH_LAST, ramp-down walks CH_LAST..CH_FIRST.
    localparam logic [IDX_W-1:0] CH_FIRST = CH_DRAM02;
    localparam logic [IDX_W-1:0] CH_LAST  = CH_DDR3;

    // Sequencer states. ST_DBG is only reachable when the debug-init
    // feature is compiled in.
    typedef enum logic [2:0] {
        ST_WAIT_START = 3'd0,
        ST_HOLD       = 3'd1,
        ST_EDGE       = 3'd2,
        ST_CKEN_UP    = 3'd3,
        ST_RUN        = 3'd4,
        ST_CKEN_DN    = 3'd5,
        ST_DBG        = 3'd6
    } ckseq_state_e;

    // True for the states in which the DRAM must be held in reset.
    function automatic logic grst_asserted(input ckseq_state_e st);
        return (st == ST_WAIT_START) || (st == ST_HOLD) || (st == ST_CKEN_DN);
    endfunction

endpackage

// File: rtl/ctu_clsp_dnctr.sv
// Loadable saturating down-counter with a zero flag.
// Load has priority over decrement; a decrement at zero leaves it at zero,
// so "zero" stays asserted until the next load.
module ctu_clsp_dnctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ctu_clsp_dram_ckseq.sv
// DRAM-domain reset / clock-enable sequencer.
// Drives the *_dg controls of the DRAM global interface stage: holds DRAM in
// reset, releases it on a sync edge, ramps the six cken channels up one at a
// time with a programmable gap, and ramps them down again on a warm reset.
// Optional debug-init path is compiled in with CTU_CKSEQ_DBGINIT_EN; without
// it the DBG state is unreachable and the debug-init outputs stay 0.
// All outputs come straight from flops.
module ctu_clsp_dram_ckseq
    import ctu_clsp_dram_ckseq_pkg::*;
#(
    parameter int STG_W = 4,
    parameter int HLD_W = 8
) (
    input  logic             dram_gclk,
    input  logic             io_pwron_rst_l,
    input  logic             start_clk_dg,
    input  logic             dram_sync_edge_dg,
    input  logic             grst_req_dg,
    input  logic             dbginit_req_dg,
    input  logic [5:0]       cken_mask,
    input  logic [STG_W-1:0] stagger_cnt,
    input  logic [HLD_W-1:0] hold_cnt,
    output logic             a_grst_dg,
    output logic             a_dbginit_dg,
    output logic             de_grst_dsync_edge_dg,
    output logic             de_dbginit_dsync_edge_dg,
    output logic [5:0]       cken_dg,
    output logic             seq_busy
);

    // Sequencer state and bookkeeping.
    ckseq_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pend_q, pend_d;

    // Registered outputs.
    logic              a_grst_q, a_grst_d;
    logic              a_dbginit_q, a_dbginit_d;
    logic              de_grst_q, de_grst_d;
    logic              de_dbginit_q, de_dbginit_d;
    logic [NUM_CH-1:0] cken_q, cken_d;
    logic              busy_q, busy_d;

    // Counter controls.
    logic hold_load, hold_dec, hold_zero;
    logic gap_load, gap_dec, gap_zero;

    // One-hot decode of the channel currently being stepped.
    logic [NUM_CH-1:0] idx_sel;

`ifndef CTU_CKSEQ_DBGINIT_EN
    // The debug-init request has no consumer in this build.
    logic dbginit_req_unused;
    assign dbginit_req_unused = dbginit_req_dg;
`endif

    // Minimum reset hold time, also reused as the debug-init hold time.
    ctu_clsp_dnctr #(.W(HLD_W)) u_hold_ctr (
        .clk      (dram_gclk),
        .rst_n    (io_pwron_rst_l),
        .load     (hold_load),
        .load_val (hold_cnt),
        .dec      (hold_dec),
        .zero     (hold_zero)
    );

    // Gap between successive cken steps, reloaded after every step.
    ctu_clsp_dnctr #(.W(STG_W)) u_gap_ctr (
        .clk      (dram_gclk),
        .rst_n    (io_pwron_rst_l),
        .load     (gap_load),
        .load_val (stagger_cnt),
        .dec      (gap_dec),
        .zero     (gap_zero)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_idx_sel
            assign idx_sel[gi] = (idx_q == IDX_W'(gi));
        end
    endgenerate

    // State, output and bookkeeping registers.
    always_ff @(posedge dram_gclk or negedge io_pwron_rst_l) begin
        if (!io_pwron_rst_l) begin
            state_q      <= ST_WAIT_START;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            a_grst_q     <= 1'b1;
            a_dbginit_q  <= 1'b0;
            de_grst_q    <= 1'b0;
            de_dbginit_q <= 1'b0;
            cken_q       <= '0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            a_grst_q     <= a_grst_d;
            a_dbginit_q  <= a_dbginit_d;
            de_grst_q    <= de_grst_d;
            de_dbginit_q <= de_dbginit_d;
            cken_q       <= cken_d;
            busy_q       <= busy_d;
        end
    end

    // Next state, channel index, pending warm-reset flag and counter controls.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        hold_load = 1'b0;
        hold_dec  = 1'b0;
        gap_load  = 1'b0;
        gap_dec   = 1'b0;

        if (!start_clk_dg) begin
            // Clock stop overrides everything and forgets any pending request.
            state_d = ST_WAIT_START;
            idx_d   = '0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_START: begin
                    state_d   = ST_HOLD;
                    hold_load = 1'b1;
                end

                ST_HOLD: begin
                    hold_dec = 1'b1;
                    if (grst_req_dg) begin
                        pend_d = 1'b1;
                    end
                    if (hold_zero && dram_sync_edge_dg) begin
                        state_d = ST_EDGE;
                    end
                end

                ST_EDGE: begin
                    if (grst_req_dg) begin
                        pend_d = 1'b1;
                    end
                    state_d  = ST_CKEN_UP;
                    idx_d    = CH_FIRST;
                    gap_load = 1'b1;
                end

                ST_CKEN_UP: begin
                    if (grst_req_dg) begin
                        pend_d = 1'b1;
                    end
                    if (gap_zero) begin
                        gap_load = 1'b1;
                        if (idx_q == CH_LAST) begin
                            state_d = ST_RUN;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        gap_dec = 1'b1;
                    end
                end

                ST_RUN: begin
                    // A warm reset (new or held over from the ramp) beats debug-init.
                    if (pend_q || grst_req_dg) begin
                        state_d  = ST_CKEN_DN;
                        pend_d   = 1'b0;
                        idx_d    = CH_LAST;
                        gap_load = 1'b1;
                    end
`ifdef CTU_CKSEQ_DBGINIT_EN
                    else if (dbginit_req_dg) begin
                        state_d   = ST_DBG;
                        hold_load = 1'b1;
                    end
`endif
                end

                ST_CKEN_DN: begin
                    if (gap_zero) begin
                        if (idx_q == CH_FIRST) begin
                            state_d   = ST_HOLD;
                            hold_load = 1'b1;
                        end else begin
                            idx_d    = idx_q - IDX_W'(1);
                            gap_load = 1'b1;
                        end
                    end else begin
                        gap_dec = 1'b1;
                    end
                end

`ifdef CTU_CKSEQ_DBGINIT_EN
                ST_DBG: begin
                    if (grst_req_dg) begin
                        state_d  = ST_CKEN_DN;
                        idx_d    = CH_LAST;
                        gap_load = 1'b1;
                    end else begin
                        hold_dec = 1'b1;
                        if (hold_zero && dram_sync_edge_dg) begin
                            state_d = ST_RUN;
                        end
                    end
                end
`endif

                default: begin
                    state_d = ST_WAIT_START;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                end
            endcase
        end
    end

    // Next output values, derived from the state being entered.
    always_comb begin
        a_grst_d     = grst_asserted(state_d);
        busy_d       = (state_d != ST_RUN);
        de_grst_d    = (state_d == ST_EDGE);
`ifdef CTU_CKSEQ_DBGINIT_EN
        a_dbginit_d  = (state_d == ST_DBG);
        de_dbginit_d = (state_q == ST_DBG) && (state_d == ST_RUN);
`else
        a_dbginit_d  = 1'b0;
        de_dbginit_d = 1'b0;
`endif

        cken_d = cken_q;
        case (state_q)
            ST_CKEN_UP: begin
                // Each step copies one mask bit, so masked-off channels still
                // take their full gap and the ramp timing is mask independent.
                if (gap_zero) begin
                    cken_d = (cken_q & ~idx_sel) | (cken_mask & idx_sel);
                end
            end
            ST_RUN: begin
                cken_d = cken_mask;
            end
            ST_CKEN_DN: begin
                if (gap_zero) begin
                    cken_d = cken_q & ~idx_sel;
                end
            end
            default: begin
                cken_d = cken_q;
            end
        endcase

        if (state_d == ST_WAIT_START) begin
            cken_d = '0;
        end
    end

    assign a_grst_dg                = a_grst_q;
    assign a_dbginit_dg             = a_dbginit_q;
    assign de_grst_dsync_edge_dg    = de_grst_q;
    assign de_dbginit_dsync_edge_dg = de_dbginit_q;
    assign cken_dg                  = cken_q;
    assign seq_busy                 = busy_q;

endmodule

// File: tb/tb_ctu_clsp_dram_ckseq.sv
// Scoreboard bench for ctu_clsp_dram_ckseq.
// The stimulus process drives one cycle of inputs at each falling edge, steps
// a phase/elapsed-time reference model and queues the expected outputs; the
// monitor pops one entry after every rising edge and compares.
module tb_ctu_clsp_dram_ckseq;

    localparam int STG_W = 4;
    localparam int HLD_W = 8;
`ifdef CTU_CKSEQ_DBGINIT_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

    logic             dram_gclk = 1'b0;
    logic             io_pwron_rst_l;
    logic             start_clk_dg;
    logic             dram_sync_edge_dg;
    logic             grst_req_dg;
    logic             dbginit_req_dg;
    logic [5:0]       cken_mask;
    logic [STG_W-1:0] stagger_cnt;
    logic [HLD_W-1:0] hold_cnt;
    logic             a_grst_dg;
    logic             a_dbginit_dg;
    logic             de_grst_dsync_edge_dg;
    logic             de_dbginit_dsync_edge_dg;
    logic [5:0]       cken_dg;
    logic             seq_busy;

    always #5 dram_gclk = ~dram_gclk;

    ctu_clsp_dram_ckseq #(.STG_W(STG_W), .HLD_W(HLD_W)) dut (
        .dram_gclk                (dram_gclk),
        .io_pwron_rst_l           (io_pwron_rst_l),
        .start_clk_dg             (start_clk_dg),
        .dram_sync_edge_dg        (dram_sync_edge_dg),
        .grst_req_dg              (grst_req_dg),
        .dbginit_req_dg           (dbginit_req_dg),
        .cken_mask                (cken_mask),
        .stagger_cnt              (stagger_cnt),
        .hold_cnt                 (hold_cnt),
        .a_grst_dg                (a_grst_dg),
        .a_dbginit_dg             (a_dbginit_dg),
        .de_grst_dsync_edge_dg    (de_grst_dsync_edge_dg),
        .de_dbginit_dsync_edge_dg (de_dbginit_dsync_edge_dg),
        .cken_dg                  (cken_dg),
        .seq_busy                 (seq_busy)
    );

    // Reference model: phase plus cycles elapsed in that phase.
    typedef enum int {P_WAIT, P_HOLD, P_EDGE, P_UP, P_RUN, P_DN, P_DBG} phase_t;
    phase_t      m_ph;
    int          m_t;
    bit          m_pend;
    logic [10:0] m_out;

    logic [10:0] exp_q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;

    // Stimulus configuration, copied onto the ports inside tick().
    logic       cfg_rst_n;
    logic       cfg_start;
    logic [5:0] cfg_mask;
    int         cfg_stag;
    int         cfg_hold;
    int         sync_per;

    function automatic logic [10:0] pack(input logic agrst, input logic adbg,
                                         input logic degrst, input logic dedbg,
                                         input logic busy, input logic [5:0] ck);
        return {agrst, adbg, degrst, dedbg, busy, ck};
    endfunction

    function automatic void model_reset();
        m_ph   = P_WAIT;
        m_t    = 0;
        m_pend = 1'b0;
        m_out  = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00);
    endfunction

    function automatic void model_step(input logic start, input logic sync,
                                       input logic grst, input logic dbg,
                                       input logic [5:0] mask, input int stag,
                                       input int hold);
        phase_t     nph;
        bit         np;
        logic [5:0] nck;
        bit         dd;
        int         ch;
        int         per;
        nph = m_ph;
        np  = m_pend;
        nck = m_out[5:0];
        dd  = 1'b0;
        per = stag + 1;
        if (!start) begin
            nph = P_WAIT;
            np  = 1'b0;
        end else begin
            case (m_ph)
                P_WAIT: nph = P_HOLD;
                P_HOLD: begin
                    if (grst) np = 1'b1;
                    if (m_t >= hold && sync) nph = P_EDGE;
                end
                P_EDGE: begin
                    if (grst) np = 1'b1;
                    nph = P_UP;
                end
                P_UP: begin
                    if (grst) np = 1'b1;
                    if (m_t % per == per - 1) begin
                        ch      = m_t / per;
                        nck[ch] = mask[ch];
                        if (ch == 5) nph = P_RUN;
                    end
                end
                P_RUN: begin
                    nck = mask;
                    if (m_pend || grst) begin
                        nph = P_DN;
                        np  = 1'b0;
                    end else if (DBG_EN && dbg) begin
                        nph = P_DBG;
                    end
                end
                P_DN: begin
                    if (m_t % per == per - 1) begin
                        ch      = 5 - m_t / per;
                        nck[ch] = 1'b0;
                        if (ch == 0) nph = P_HOLD;
                    end
                end
                P_DBG: begin
                    if (grst) begin
                        nph = P_DN;
                    end else if (m_t >= hold && sync) begin
                        nph = P_RUN;
                        dd  = 1'b1;
                    end
                end
                default: nph = P_WAIT;
            endcase
        end
        if (nph == P_WAIT) nck = 6'h00;
        m_t    = (nph == m_ph) ? m_t + 1 : 0;
        m_ph   = nph;
        m_pend = np;
        m_out  = pack(nph == P_WAIT || nph == P_HOLD || nph == P_DN, nph == P_DBG,
                      nph == P_EDGE, dd, nph != P_RUN, nck);
    endfunction

    function automatic void check_out(input string name, input logic [10:0] exp);
        logic [10:0] act;
        act = pack(a_grst_dg, a_dbginit_dg, de_grst_dsync_edge_dg,
                   de_dbginit_dsync_edge_dg, seq_busy, cken_dg);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t got agrst=%b adbg=%b degrst=%b dedbg=%b busy=%b cken=%h expected agrst=%b adbg=%b degrst=%b dedbg=%b busy=%b cken=%h",
                     name, $time, act[10], act[9], act[8], act[7], act[6], act[5:0],
                     exp[10], exp[9], exp[8], exp[7], exp[6], exp[5:0]);
        end
    endfunction

    // One clock of stimulus: drive inputs, advance the model, queue expectation.
    task automatic tick(input logic grst, input logic dbg);
        logic sync;
        @(negedge dram_gclk);
        cyc++;
        sync              = ((cyc % sync_per) == 0);
        io_pwron_rst_l    = cfg_rst_n;
        start_clk_dg      = cfg_start;
        dram_sync_edge_dg = sync;
        grst_req_dg       = grst;
        dbginit_req_dg    = dbg;
        cken_mask         = cfg_mask;
        stagger_cnt       = STG_W'(cfg_stag);
        hold_cnt          = HLD_W'(cfg_hold);
        if (!cfg_rst_n) model_reset();
        else model_step(cfg_start, sync, grst, dbg, cfg_mask, cfg_stag, cfg_hold);
        exp_q.push_back(m_out);
    endtask

    task automatic run_until(input phase_t p, input int max_cyc);
        for (int i = 0; i < max_cyc && m_ph != p; i++) tick(1'b0, 1'b0);
    endtask

    // Drop the configuration safely: stop the clock for one cycle, then apply.
    task automatic restart(input int stag, input int hold, input logic [5:0] mask, input int per);
        cfg_start = 1'b0;
        tick(1'b0, 1'b0);
        cfg_stag  = stag;
        cfg_hold  = hold;
        cfg_mask  = mask;
        sync_per  = per;
        cfg_start = 1'b1;
    endtask

    task automatic async_reset_mid();
        @(negedge dram_gclk);
        #2;
        io_pwron_rst_l = 1'b0;
        cfg_rst_n      = 1'b0;
        #1;
        check_out("async_reset", pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'h00));
        model_reset();
    endtask

    // Monitor: every cycle presents an output word; compare against the queue.
    initial begin
        logic [10:0] e;
        forever begin
            @(posedge dram_gclk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_out("outputs", e);
            end
        end
    end

    // Stimulus.
    initial begin
        io_pwron_rst_l    = 1'b0;
        start_clk_dg      = 1'b0;
        dram_sync_edge_dg = 1'b0;
        grst_req_dg       = 1'b0;
        dbginit_req_dg    = 1'b0;
        cken_mask         = 6'h00;
        stagger_cnt       = '0;
        hold_cnt          = '0;
        cfg_rst_n         = 1'b0;
        cfg_start         = 1'b0;
        cfg_mask          = 6'h3F;
        cfg_stag          = 2;
        cfg_hold          = 4;
        sync_per          = 6;
        model_reset();

        $display("txn reset: hold power-on reset 3 cycles");
        repeat (3) tick(1'b0, 1'b0);
        cfg_rst_n = 1'b1;

        $display("txn bring-up: hold=4 stagger=2 mask=3f sync every 6");
        cfg_start = 1'b1;
        run_until(P_RUN, 200);
        repeat (3) tick(1'b0, 1'b0);

        $display("txn warm reset: grst_req pulse in RUN");
        tick(1'b1, 1'b0);
        run_until(P_RUN, 200);
        repeat (3) tick(1'b0, 1'b0);

        $display("txn simultaneous grst_req and dbginit_req in RUN");
        tick(1'b1, 1'b1);
        run_until(P_RUN, 200);
        repeat (2) tick(1'b0, 1'b0);

        $display("txn dbginit_req alone in RUN");
        tick(1'b0, 1'b1);
        repeat (20) tick(1'b0, 1'b0);

        $display("txn dbginit_req then grst_req three cycles later");
        tick(1'b0, 1'b1);
        repeat (2) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        run_until(P_RUN, 200);

        $display("txn mask skip: mask=05 stagger=0 hold=0");
        restart(0, 0, 6'h05, 3);
        run_until(P_RUN, 100);
        repeat (2) tick(1'b0, 1'b0);

        $display("txn pending: two grst_req pulses during CKEN_UP");
        restart(3, 2, 6'h3F, 4);
        run_until(P_UP, 100);
        repeat (2) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        run_until(P_DN, 100);
        run_until(P_HOLD, 100);

        $display("txn abort: start_clk drops mid CKEN_UP");
        run_until(P_UP, 100);
        repeat (5) tick(1'b0, 1'b0);
        cfg_start = 1'b0;
        repeat (2) tick(1'b0, 1'b0);

        $display("txn async reset mid CKEN_UP");
        cfg_start = 1'b1;
        run_until(P_UP, 100);
        repeat (3) tick(1'b0, 1'b0);
        async_reset_mid();
        repeat (2) tick(1'b0, 1'b0);
        cfg_rst_n = 1'b1;
        run_until(P_RUN, 200);

        for (int ep = 0; ep < 20; ep++) begin
            restart($urandom_range(0, 15), $urandom_range(0, 12),
                    6'($urandom_range(0, 63)), $urandom_range(1, 8));
            $display("txn random episode %0d: stagger=%0d hold=%0d mask=%h sync_per=%0d",
                     ep, cfg_stag, cfg_hold, cfg_mask, sync_per);
            for (int c = 0; c < 250; c++) begin
                cfg_start = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
                if ($urandom_range(0, 99) < 2) cfg_mask = 6'($urandom_range(0, 63));
                tick(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0);
            end
        end

        @(posedge dram_gclk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
